// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } e_arb_state;

    typedef enum logic {
        OWNER_IF,
        OWNER_LS
    } e_arb_owner;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts LS grants made while IF waits; raises force_if once the limit is reached.
// Latency: force_if is a registered-count compare, valid the cycle after the last LS grant.
// Backpressure: none; it only observes grants.
// Ports: clk/rst, if_req_valid (IF waiting), ls_grant / if_grant (handshakes), force_if.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_valid,
    input  logic ls_grant,
    input  logic if_grant,
    output logic force_if
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at the limit so a flush-blocked IF cannot wrap the count
    // back to zero while LS keeps winning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (if_grant || !if_req_valid) begin
            cnt <= '0;
        end else if (ls_grant && (cnt != CNT_W'(STARVE_LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign force_if = (cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS), one transaction outstanding.
// Latency: request handshake at edge N, memory response earliest N+1, requester response registered one cycle later.
// Backpressure: winner's ready follows mem_req_ready in ARB_IDLE; both readies are low while a transaction is outstanding.
// Ports: flush kills pending/in-flight IF traffic; if_req_*/if_rsp_* fetch side; ls_req_*/ls_rsp_* load/store side;
//        mem_req_*/mem_rsp_* memory controller; protocol_err sticky flag for an unsolicited memory response.
// Build option MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive LS grants with IF waiting, IF gets the next grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_req_we,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                protocol_err
);

    if (STARVE_LIMIT == 0) begin : g_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    e_arb_state state, state_nxt;
    e_arb_owner owner, owner_nxt;
    logic       drop;
    logic       ls_we_q;
    logic       force_if;
    logic       if_elig;
    logic       grant_ls;
    logic       grant_if;
    logic       req_hs;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .ls_grant     (ls_req_valid && ls_req_ready),
        .if_grant     (if_req_valid && if_req_ready),
        .force_if     (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // A fetch raised in the same cycle as a redirect is already stale.
    assign if_elig  = if_req_valid && !flush;
    assign grant_ls = ls_req_valid && !(force_if && if_elig);
    assign grant_if = if_elig && !grant_ls;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
            owner <= OWNER_IF;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        mem_req_valid = 1'b0;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        req_hs        = 1'b0;
        if (grant_ls) begin
            mem_req_we    = ls_req_we;
            mem_req_addr  = ls_req_addr;
            mem_req_wdata = ls_req_wdata;
            mem_req_wstrb = ls_req_wstrb;
        end else begin
            mem_req_we    = 1'b0;
            mem_req_addr  = if_req_addr;
            mem_req_wdata = '0;
            mem_req_wstrb = '0;
        end
        case (state)
            ARB_IDLE: begin
                mem_req_valid = grant_ls || grant_if;
                ls_req_ready  = grant_ls && mem_req_ready;
                if_req_ready  = grant_if && mem_req_ready;
                req_hs        = mem_req_valid && mem_req_ready;
                if (req_hs) begin
                    state_nxt = ARB_WAIT;
                    owner_nxt = grant_ls ? OWNER_LS : OWNER_IF;
                end
            end
            ARB_WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop         <= 1'b0;
            ls_we_q      <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            if (state == ARB_IDLE) begin
                if (ls_req_valid && ls_req_ready) begin
                    ls_we_q <= ls_req_we;
                end
                if (mem_rsp_valid) begin
                    protocol_err <= 1'b1;
                end
            end else begin
                if (mem_rsp_valid) begin
                    drop <= 1'b0;
                    if (owner == OWNER_LS) begin
                        ls_rsp_valid <= 1'b1;
                        ls_rsp_data  <= ls_we_q ? '0 : mem_rsp_data;
                    end else if (!drop && !flush) begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= mem_rsp_data;
                    end
                end else if (flush && (owner == OWNER_IF)) begin
                    drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing the core's one memory interface between instruction fetch (IF) and the load/store path (LS). It sits between the fetch/memory stages and the memory controller. It accepts valid/ready requests from both sides and issues at most one outstanding transaction. Each response is routed back to the requester that owns the transaction, and a stale fetch response is dropped on a pipeline flush.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (`DATA_W/8` byte strobes)
- `STARVE_LIMIT`, 4, consecutive LS grants tolerated while IF waits (used only with the guard compiled in)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `flush`  in  1  fetch redirect from writeback; kills in-flight/pending IF traffic
- `if_req_valid`  in  1  fetch request
- `if_req_ready`  out  1  fetch request accepted this cycle
- `if_req_addr`  in  ADDR_W  fetch address
- `if_rsp_valid`  out  1  fetch data valid, one-cycle pulse
- `if_rsp_data`  out  DATA_W  fetched instruction
- `ls_req_valid`  in  1  load/store request
- `ls_req_ready`  out  1  LS request accepted this cycle
- `ls_req_we`  in  1  1 = store
- `ls_req_addr`  in  ADDR_W  LS address
- `ls_req_wdata`  in  DATA_W  store data
- `ls_req_wstrb`  in  DATA_W/8  store byte enables
- `ls_rsp_valid`  out  1  load data / store ack, one-cycle pulse
- `ls_rsp_data`  out  DATA_W  load data; 0 for store acks
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  muxed request fields
- `mem_rsp_valid`  in  1  exactly one per accepted request, read or write
- `mem_rsp_data`  in  DATA_W  read data
- `protocol_err`  out  1  sticky: `mem_rsp_valid` seen with no transaction outstanding

## Operation
- The FSM has two states, `ARB_IDLE` and `ARB_WAIT`. It also holds an owner register (`OWNER_IF`/`OWNER_LS`) and a `drop` flag.
- ARB_IDLE:
  - Pick a winner. LS beats IF. IF is ineligible in any cycle where `flush`=1.
  - `mem_req_*` = winner's fields (combinational); `mem_req_valid` = winner valid.
  - Winner's `*_req_ready` = `mem_req_ready`; the loser's ready = 0.
  - On handshake: latch owner, go to ARB_WAIT.
- ARB_WAIT:
  - `mem_req_valid`=0 and both readies = 0.
  - On `mem_rsp_valid`: return to ARB_IDLE.
  - Register the response into the owner's `*_rsp_valid`/`*_rsp_data`, except suppress it if owner=IF and `drop`=1. `drop` then clears.
- Flush:
  - `flush` in ARB_WAIT with owner=IF sets `drop`.
  - `flush` in the same cycle as `mem_rsp_valid` for an IF transaction also suppresses that response.
  - `flush` never affects LS.
- Store ack: `ls_rsp_valid`=1 with `ls_rsp_data`=0.
- Error: `mem_rsp_valid` in ARB_IDLE is ignored and sets `protocol_err`, which holds until reset.
- Requesters must hold their fields stable while valid and not ready. The arbiter does not check this.

## Timing
- Reset values:
  - State ARB_IDLE, owner IF, `drop`=0, starvation counter 0.
  - `if_rsp_valid`=`ls_rsp_valid`=0; both rsp data = 0; `protocol_err`=0.
  - Combinational outputs follow from the ARB_IDLE state.
- Latency:
  - Request handshake at edge N.
  - `mem_rsp_valid` earliest in cycle N+1.
  - `*_rsp_valid` appears in the cycle after `mem_rsp_valid`, and is high in the same cycle that the next request can handshake.
  - Peak throughput is 1 transaction / 2 cycles with a zero-wait memory.
- Reset mid-transaction: the outstanding transaction is abandoned and no response is delivered. Memory is reset in the same domain.
- Simultaneous IF and LS valid in ARB_IDLE: LS is granted, except as set by the guard below.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each LS grant made while `if_req_valid`=1.
  - It clears on an IF grant or whenever `if_req_valid`=0.
  - When the count equals `STARVE_LIMIT`, the next ARB_IDLE grant goes to IF (if eligible) regardless of LS.
- Undefined: strict LS priority and no counter logic. IF may starve indefinitely.

## Structure
- Package `mem_arb_pkg` holds:
  - `e_arb_state` {ARB_IDLE, ARB_WAIT}
  - `e_arb_owner` {OWNER_IF, OWNER_LS}
  - the default width constants
- One sub-module, `mem_arb_starve_ctr` (counter plus force-IF output), is instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- IF-only read of 0x100; memory returns 0x00000013 one cycle later -> `if_rsp_valid` pulse with 0x00000013 two cycles after the handshake; `ls_rsp_valid` stays 0.
- IF and LS valid together; LS load of 0x2000 returns 0xDEADBEEF -> LS granted first, `ls_rsp_data`=0xDEADBEEF; IF granted in the cycle the LS response is presented.
- LS store to 0x2004 with wdata 0xA5A5A5A5, wstrb 0x3 -> `mem_req_we`=1 with matching wstrb; `ls_rsp_valid` pulse with data 0.
- IF read outstanding; `flush` pulses in ARB_WAIT -> memory response consumed, `if_rsp_valid` never asserts, FSM returns to ARB_IDLE, next IF read is delivered normally.
- Guard compiled in, `STARVE_LIMIT`=4, LS valid continuously and IF valid -> exactly 4 LS grants, then 1 IF grant, repeating. Guard compiled out -> zero IF grants over 20 transactions.
- `mem_rsp_valid` asserted in ARB_IDLE -> `protocol_err`=1 and stays 1 until `rst` is low; `rst` asserted during ARB_WAIT -> all outputs at reset values, no rsp pulse.
